math_sched_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer that shares one (a+b)*c datapath (complex_math: 8-bit adder

---
 rtl/math_sched_arbiter.sv | 115 +++++++++++
 tb/tb_math_sched_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/math_sched_arbiter.sv
// math_sched_arbiter: round-robin sequencer sharing one (a+b)*c datapath among NUM_REQ requesters.
// Define MATH_SCHED_STATS_EN to add the done_cnt_o completed-operation counter.
module math_sched_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 8,
    parameter  int RES_W   = 2*DATA_W,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_c_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [RES_W-1:0]          rsp_result_o,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic                      busy_o
`ifdef MATH_SCHED_STATS_EN
    ,
    output logic [15:0]               done_cnt_o
`endif
);
    typedef enum logic [1:0] {IDLE, ADD, MUL, RESP} state_t;
    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d, id_q, id_d, gnt;
    logic                gnt_vld;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d, sum_q, sum_d;
    logic [RES_W-1:0]    res_q, res_d;
    logic [15:0]         cnt_q, cnt_d;

    // First valid requester strictly after the last grant, wrapping.
    always_comb begin
        logic [ID_W-1:0] idx;
        gnt     = '0;
        gnt_vld = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!gnt_vld && req_valid_i[idx]) begin
                gnt_vld = 1'b1;
                gnt     = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        sum_d       = sum_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        req_ready_o = '0;
        case (state_q)
            IDLE: if (gnt_vld) begin
                req_ready_o[gnt] = 1'b1;
                a_d     = req_a_i[int'(gnt)*DATA_W +: DATA_W];
                b_d     = req_b_i[int'(gnt)*DATA_W +: DATA_W];
                c_d     = req_c_i[int'(gnt)*DATA_W +: DATA_W];
                ptr_d   = gnt;
                state_d = ADD;
            end
            ADD: begin
                sum_d   = a_q + b_q;
                state_d = MUL;
            end
            MUL: begin
                res_d   = RES_W'(sum_q) * RES_W'(c_q);
                id_d    = ptr_q;
                state_d = RESP;
            end
            RESP: if (rsp_ready_i) begin
                cnt_d   = cnt_q + 16'd1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= ID_W'(NUM_REQ-1);
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            sum_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rsp_valid_o  = state_q == RESP;
    assign busy_o       = state_q != IDLE;
    assign rsp_result_o = res_q;
    assign rsp_id_o     = id_q;
`ifdef MATH_SCHED_STATS_EN
    assign done_cnt_o   = cnt_q;
`endif
endmodule

// File: tb/tb_math_sched_arbiter.sv
// tb_math_sched_arbiter: directed and random checks of math_sched_arbiter against a transaction-level model.
module tb_math_sched_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;
    logic [N-1:0]   vld, req_ready;
    logic [N*W-1:0] req_a, req_b, req_c;
    logic [W-1:0]   ra[N], rb[N], rc[N];
    logic           rsp_valid, rsp_ready, busy;
    logic [15:0]    rsp_result;
    logic [1:0]     rsp_id;
`ifdef MATH_SCHED_STATS_EN
    logic [15:0]    done_cnt;
`endif
    for (genvar i = 0; i < N; i++) begin : g_pack
        assign req_a[i*W +: W] = ra[i];
        assign req_b[i*W +: W] = rb[i];
        assign req_c[i*W +: W] = rc[i];
    end

    math_sched_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(vld), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b), .req_c_i(req_c),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result), .rsp_id_o(rsp_id),
        .busy_o(busy)
`ifdef MATH_SCHED_STATS_EN
        , .done_cnt_o(done_cnt)
`endif
    );

    int n_tests = 0, n_fail = 0;
    bit pend, hold;
    int p_id, p_res, p_t, last, cyc, done, last_res, last_id;
    int gl[$], gc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_req(input int i, input int a, input int b, input int c);
        vld[i] = 1'b1;
        ra[i] = 8'(a);
        rb[i] = 8'(b);
        rc[i] = 8'(c);
    endtask

    // One clock: check outputs against the transaction model, then advance it.
    task automatic step();
        int g;
        bit ev;
        #1;
        g = -1;
        if (!pend)
            for (int k = 1; k <= N; k++)
                if (g < 0 && vld[(last+k)%N]) g = (last+k)%N;
        chk("req_ready", 32'(req_ready), g >= 0 ? (1 << g) : 0);
        chk("busy", 32'(busy), 32'(pend));
        ev = pend && (cyc >= p_t + 3);
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        if (ev) begin
            chk("rsp_result", 32'(rsp_result), p_res);
            chk("rsp_id", 32'(rsp_id), p_id);
        end
`ifdef MATH_SCHED_STATS_EN
        chk("done_cnt", 32'(done_cnt), done & 16'hFFFF);
`endif
        if (ev && rsp_ready) begin
            pend = 1'b0;
            done++;
            last_res = int'(rsp_result);
            last_id = int'(rsp_id);
        end
        if (g >= 0) begin
            pend = 1'b1;
            p_id = g;
            p_res = ((int'(ra[g]) + int'(rb[g])) % 256) * int'(rc[g]);
            p_t = cyc;
            last = g;
            gl.push_back(g);
            gc.push_back(cyc);
        end
        @(negedge clk);
        cyc++;
        if (g >= 0) begin
            if (hold) begin
                ra[g] = 8'($urandom);
                rb[g] = 8'($urandom);
                rc[g] = 8'($urandom);
            end else vld[g] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        vld = '0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_result", 32'(rsp_result), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_busy", 32'(busy), 0);
`ifdef MATH_SCHED_STATS_EN
        chk("rst_done_cnt", 32'(done_cnt), 0);
`endif
        pend = 1'b0;
        last = N - 1;
        done = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int s;
        vld = '0;
        hold = 1'b0;
        rsp_ready = 1'b1;
        cyc = 0;
        for (int i = 0; i < N; i++) begin
            ra[i] = '0;
            rb[i] = '0;
            rc[i] = '0;
        end
        do_reset();
        repeat (3) step();
        set_req(2, 10, 20, 3);
        repeat (5) step();
        chk("single_res", last_res, 90);
        chk("single_id", last_id, 2);
        set_req(0, 200, 100, 255);
        repeat (5) step();
        chk("wrap_res", last_res, 32'h2BD4);
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, i + 1, i + 2, i + 3);
        hold = 1'b1;
        s = gl.size();
        repeat (20) step();
        hold = 1'b0;
        for (int k = 0; k < 5; k++) chk("contend_order", gl[s+k], k % N);
        for (int k = 0; k < 4; k++) chk("contend_gap", gc[s+k+1] - gc[s+k], 4);
        do_reset();
        set_req(1, 7, 9, 11);
        set_req(3, 250, 10, 200);
        rsp_ready = 1'b0;
        repeat (8) step();
        rsp_ready = 1'b1;
        repeat (2) step();
        chk("bp_next_grant", gl[$], 3);
        repeat (4) step();
        do_reset();
        repeat (3) begin
            set_req(1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            repeat (4) step();
        end
`ifdef MATH_SCHED_STATS_EN
        chk("stats_three", 32'(done_cnt), 3);
`endif
        set_req(2, 1, 2, 3);
        repeat (2) step();
        do_reset();
        set_req(0, 5, 6, 7);
        set_req(2, 8, 9, 10);
        step();
        chk("post_rst_grant", gl[$], 0);
        vld = '0;
        repeat (4) step();
        do_reset();
        repeat (400) begin
            for (int i = 0; i < N; i++)
                if (!vld[i] && $urandom_range(0, 3) == 0)
                    set_req(i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            rsp_ready = $urandom_range(0, 3) != 0;
            step();
        end
        vld = '0;
        rsp_ready = 1'b1;
        repeat (6) step();
        chk("drain_idle", 32'(busy), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
